// File: rtl/pdp8_iot_pkg.sv
// Shared PDP-8 IOT definitions: device codes and the teleprinter FSM state encoding.
package pdp8_iot_pkg;

  localparam logic [2:0] DEV_KBD = 3'b011;
  localparam logic [2:0] DEV_TTY = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tty_state_t;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: down-counts CLKS_PER_BIT cycles while run is high and pulses bit_tick
// on the last cycle of each period; restart reloads so the next period is a full one.
module baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 16'd0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (run) begin
      if (cnt == 16'd0) begin
        cnt <= RELOAD;
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  assign bit_tick = run && (cnt == 16'd0);

endmodule

// File: rtl/tty_printer.sv
// PDP-8 teleprinter (device 4): latches a character on a load strobe and sends it 8N1 on txd.
// The printer flag (ready) is set when the stop bit ends and cleared by the clear strobe.
module tty_printer
  import pdp8_iot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] dataout,
  output logic       ready,
  output logic       clearacc,
  output logic [7:0] datain,
  output logic       busy,
  output logic       txd
);

  tty_state_t state;
  tty_state_t state_next;

  logic       load_q;
  logic       clear_q;
  logic       load_edge;
  logic       clear_edge;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       bit_tick;
  logic       start_frame;
  logic       frame_done;

  assign load_edge  = load  && !load_q;
  assign clear_edge = clear && !clear_q;

  assign clearacc = 1'b0;
  assign datain   = 8'h00;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (start_frame),
    .run     (busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state   <= state_next;
      load_q  <= load;
      clear_q <= clear;
    end
  end

  // Load edges outside IDLE fall through untouched, so a busy printer drops the character.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (load_edge) begin
          state_next  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txd  = 1'b1;
    busy = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   txd  = 1'b0;
      DATA:    txd  = shreg[0];
      STOP:    txd  = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if (start_frame) begin
      shreg <= dataout;
    end else if ((state == DATA) && bit_tick) begin
      shreg   <= {1'b0, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Set has priority so a clear landing on the completion cycle cannot lose the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
    end else if (frame_done) begin
      ready <= 1'b1;
    end else if (clear_edge) begin
      ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tty_printer.sv
// Directed bench for tty_printer with CLKS_PER_BIT=4 (frame = 40 cycles).
module tb_tty_printer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] dataout = 8'h00;
  logic       ready;
  logic       clearacc;
  logic [7:0] datain;
  logic       busy;
  logic       txd;

  int n_chk  = 0;
  int n_fail = 0;

  tty_printer #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .clear   (clear),
    .dataout (dataout),
    .ready   (ready),
    .clearacc(clearacc),
    .datain  (datain),
    .busy    (busy),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample 1 time unit after the rising edge, constants checked every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("clearacc", {7'd0, clearacc}, 8'h00);
    chk("datain", datain, 8'h00);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_txd", {7'd0, txd}, 8'h01);
      chk("idle_busy", {7'd0, busy}, 8'h00);
    end
  endtask

  // Called at the first sample after the load edge. Checks all 40 frame cycles and completion.
  task automatic check_frame(input logic [7:0] expd, input int lower_k, input int inj_k,
                             input bit clr_end);
    logic exp_bit;
    for (int k = 0; k < 40; k++) begin
      if (k < 4) exp_bit = 1'b0;
      else if (k < 36) exp_bit = expd[(k - 4) / 4];
      else exp_bit = 1'b1;
      chk($sformatf("txd_k%0d", k), {7'd0, txd}, {7'd0, exp_bit});
      chk($sformatf("busy_k%0d", k), {7'd0, busy}, 8'h01);
      chk($sformatf("ready_k%0d", k), {7'd0, ready}, 8'h00);
      if (k == lower_k) begin
        load  = 1'b0;
        clear = 1'b0;
      end
      if (k == inj_k) begin
        dataout = 8'hFF;
        load    = 1'b1;
      end
      if (k == inj_k + 1) load = 1'b0;
      if (clr_end && (k == 39)) clear = 1'b1;
      if (k < 39) step();
    end
    step();
    chk("done_ready", {7'd0, ready}, 8'h01);
    chk("done_busy", {7'd0, busy}, 8'h00);
    chk("done_txd", {7'd0, txd}, 8'h01);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_txd", {7'd0, txd}, 8'h01);
    chk("rst_ready", {7'd0, ready}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    #10 reset_n = 1'b1;
    idle_check(3);

    // 8'h41 from IDLE, ready low from reset
    dataout = 8'h41;
    load    = 1'b1;
    step();
    check_frame(8'h41, 0, -1, 1'b0);
    idle_check(3);

    // 8'h55 with load held 3 cycles; simultaneous clear drops ready while the frame starts
    dataout = 8'h55;
    load    = 1'b1;
    clear   = 1'b1;
    step();
    check_frame(8'h55, 2, -1, 1'b0);
    idle_check(10);

    // 8'h41 with an 8'hFF load at cycle 12 of the frame: must be dropped
    dataout = 8'h41;
    load    = 1'b1;
    clear   = 1'b1;
    step();
    check_frame(8'h41, 0, 11, 1'b0);
    idle_check(10);

    // Reset during DATA bit 3 of 8'hC3 with ready set beforehand
    dataout = 8'hC3;
    load    = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("pre_rst_txd", {7'd0, txd}, 8'h00);
    chk("pre_rst_busy", {7'd0, busy}, 8'h01);
    chk("pre_rst_ready", {7'd0, ready}, 8'h01);
    reset_n = 1'b0;
    #1;
    chk("midrst_txd", {7'd0, txd}, 8'h01);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    chk("midrst_ready", {7'd0, ready}, 8'h00);
    #2 reset_n = 1'b1;
    idle_check(3);

    // 8'h0F after reset, with a clear edge on the completion cycle (set wins)
    dataout = 8'h0F;
    load    = 1'b1;
    step();
    check_frame(8'h0F, 0, -1, 1'b1);
    idle_check(2);
    chk("after_clr_race_ready", {7'd0, ready}, 8'h01);

    // Isolated clear edge drops ready on the next cycle
    clear = 1'b1;
    step();
    chk("iso_clear_ready", {7'd0, ready}, 8'h00);
    clear = 1'b0;
    idle_check(2);
    chk("iso_clear_hold", {7'd0, ready}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
